// File: rtl/valid_sched_pkg.sv
// Shared defaults and FSM state encoding for the valid strobe scheduler.
package valid_sched_pkg;

    localparam int unsigned PKG_PERIOD_W   = 8;
    localparam int unsigned PKG_BURST_W    = 16;
    localparam int unsigned PKG_DEF_PERIOD = 3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/valid_sched_tick.sv
// Period counter: counts 0..period and emits a registered one-cycle tick on the
// cycle after the count reaches period, wrapping back to 0 at the same time.
module valid_tick
    import valid_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W = PKG_PERIOD_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                tick
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                tick_q, tick_d;

    // Next count and tick; clear wins over enable so a new run starts from zero.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == period) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/valid_sched.sv
// Valid strobe scheduler: issues o_valid every period+1 cycles for a burst of
// strobes (or continuously), with shadow configuration latched at run start.
module valid_sched
    import valid_sched_pkg::*;
#(
    parameter int unsigned PERIOD_W   = PKG_PERIOD_W,
    parameter int unsigned BURST_W    = PKG_BURST_W,
    parameter int unsigned DEF_PERIOD = PKG_DEF_PERIOD
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_cfg_we,
    input  logic [PERIOD_W-1:0] i_cfg_period,
    input  logic [BURST_W-1:0]  i_cfg_burst,
    input  logic                i_start,
    input  logic                i_stop,
    output logic                o_valid,
    output logic                o_busy,
    output logic                o_done,
    output logic [BURST_W-1:0]  o_count
);

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                start_run;
    logic                tick_en;
    logic                tick;

    logic [PERIOD_W-1:0] shadow_period_q, shadow_period_d;
    logic [BURST_W-1:0]  shadow_burst_q, shadow_burst_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [BURST_W-1:0]  count_q, count_d;
    logic [BURST_W-1:0]  count_inc;

    assign count_inc = count_q + 1'b1;

    // FSM, registered status outputs, config and strobe count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            shadow_period_q <= PERIOD_W'(DEF_PERIOD);
            shadow_burst_q  <= '0;
            period_q        <= PERIOD_W'(DEF_PERIOD);
            burst_q         <= '0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            shadow_period_q <= shadow_period_d;
            shadow_burst_q  <= shadow_burst_d;
            period_q        <= period_d;
            burst_q         <= burst_d;
            count_q         <= count_d;
        end
    end

    // Next-state logic; stop takes priority over start and over burst completion.
    always_comb begin
        state_d   = state_q;
        start_run = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start && !i_stop) begin
                    state_d   = StRun;
                    start_run = 1'b1;
                end
            end
            StRun: begin
                if (i_stop) begin
                    state_d = StIdle;
                end else if (tick && (burst_q != '0) && (count_inc == burst_q)) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from next state so busy/done are registered yet track the state.
    always_comb begin
        busy_d  = (state_d == StRun);
        done_d  = (state_d == StDone);
        // Ticks only continue while the run persists, so no strobe follows stop or the last one.
        tick_en = (state_d == StRun);
    end

    // Shadow config writes anytime; active copy only at run start; strobe counting.
    always_comb begin
        shadow_period_d = shadow_period_q;
        shadow_burst_d  = shadow_burst_q;
        period_d        = period_q;
        burst_d         = burst_q;
        count_d         = count_q;
        if (i_cfg_we) begin
            shadow_period_d = i_cfg_period;
            shadow_burst_d  = i_cfg_burst;
        end
        if (start_run) begin
            period_d = shadow_period_q;
            burst_d  = shadow_burst_q;
            count_d  = '0;
        end else if (tick) begin
            count_d = count_inc;
        end
    end

    valid_tick #(
        .PERIOD_W (PERIOD_W)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (start_run),
        .enable (tick_en),
        .period (period_q),
        .tick   (tick)
    );

    assign o_valid = tick;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_valid_sched.sv
// Directed bench for valid_sched: strobe timing, bursts, stop, reconfig, reset.
module tb_valid_sched;

    logic        clk;
    logic        reset;
    logic        i_cfg_we;
    logic [7:0]  i_cfg_period;
    logic [15:0] i_cfg_burst;
    logic        i_start;
    logic        i_stop;
    logic        o_valid;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_count;

    int checks;
    int errors;

    valid_sched u_dut (
        .clk          (clk),
        .reset        (reset),
        .i_cfg_we     (i_cfg_we),
        .i_cfg_period (i_cfg_period),
        .i_cfg_burst  (i_cfg_burst),
        .i_start      (i_start),
        .i_stop       (i_stop),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_count      (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_cfg(input logic [7:0] p, input logic [15:0] b);
        i_cfg_we     = 1'b1;
        i_cfg_period = p;
        i_cfg_burst  = b;
        step();
        i_cfg_we     = 1'b0;
    endtask

    // Strobe expected at relative cycle k when first at f, then every s cycles.
    function automatic logic exp_valid(input int k, input int f, input int s);
        return (k >= f) && (((k - f) % s) == 0);
    endfunction

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        i_cfg_we     = 1'b0;
        i_cfg_period = '0;
        i_cfg_burst  = '0;
        i_start      = 1'b0;
        i_stop       = 1'b0;

        // Reset state
        step();
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_done",  32'(o_done),  32'd0);
        chk("rst_count", 32'(o_count), 32'd0);
        reset = 1'b0;

        // Default config, start at cycle 10: valids at 15, 19, 23; busy from 11
        for (int c = 0; c < 10; c++) step();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 11; c <= 24; c++) begin
            chk("def_valid", 32'(o_valid), 32'(exp_valid(c, 15, 4)));
            chk("def_busy",  32'(o_busy),  32'd1);
            chk("def_done",  32'(o_done),  32'd0);
            if (c < 24) step();
        end
        chk("def_count", 32'(o_count), 32'd3);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("def_stop_busy",  32'(o_busy),  32'd0);
        chk("def_stop_valid", 32'(o_valid), 32'd0);

        // P=0, B=4: four back-to-back strobes, then done with busy low
        write_cfg(8'd0, 16'd4);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            chk("b4_valid", 32'(o_valid), 32'((k >= 2) && (k <= 5)));
            chk("b4_busy",  32'(o_busy),  32'(k <= 5));
            chk("b4_done",  32'(o_done),  32'(k == 6));
            if (k == 3) chk("b4_count_mid", 32'(o_count), 32'd1);
            if (k == 6) chk("b4_count", 32'(o_count), 32'd4);
            step();
        end

        // P=2, B=0: stop after 5 strobes, count holds 5
        write_cfg(8'd2, 16'd0);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            chk("p2_valid", 32'(o_valid), 32'(exp_valid(k, 4, 3)));
            if (k < 17) step();
        end
        chk("p2_count5", 32'(o_count), 32'd5);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("p2_stop_valid", 32'(o_valid), 32'd0);
            chk("p2_stop_done",  32'(o_done),  32'd0);
            chk("p2_stop_busy",  32'(o_busy),  32'd0);
            chk("p2_stop_count", 32'(o_count), 32'd5);
            step();
        end

        // P=2, B=2: stop in the terminal cycle of the last strobe wins
        write_cfg(8'd2, 16'd2);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk("term_valid", 32'(o_valid), 32'(k == 4));
            if (k < 6) step();
        end
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("term_valid_after", 32'(o_valid), 32'd0);
            chk("term_done",        32'(o_done),  32'd0);
            chk("term_count",       32'(o_count), 32'd1);
            step();
        end

        // P=1, B=3 with a shadow write mid-run that must not take effect yet
        write_cfg(8'd1, 16'd3);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            chk("rc_valid", 32'(o_valid), 32'((k == 3) || (k == 5) || (k == 7)));
            chk("rc_busy",  32'(o_busy),  32'(k <= 7));
            chk("rc_done",  32'(o_done),  32'(k == 8));
            if (k == 8) chk("rc_count", 32'(o_count), 32'd3);
            if (k == 2) begin
                i_cfg_we     = 1'b1;
                i_cfg_period = 8'd7;
                i_cfg_burst  = 16'd9;
            end
            step();
            i_cfg_we = 1'b0;
        end
        // Next run uses P=7: strobes at 9, 17
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            chk("p7_valid", 32'(o_valid), 32'(exp_valid(k, 9, 8)));
            chk("p7_busy",  32'(o_busy),  32'd1);
            if (k < 18) step();
        end
        chk("p7_count", 32'(o_count), 32'd2);

        // Reset between strobes: outputs clear without waiting for a clock edge
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(o_valid), 32'd0);
        chk("mid_rst_busy",  32'(o_busy),  32'd0);
        chk("mid_rst_done",  32'(o_done),  32'd0);
        chk("mid_rst_count", 32'(o_count), 32'd0);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("post_rst_valid", 32'(o_valid), 32'd0);
            chk("post_rst_busy",  32'(o_busy),  32'd0);
        end

        // Start and stop together in IDLE: stop wins
        i_start = 1'b1;
        i_stop  = 1'b1;
        step();
        i_start = 1'b0;
        i_stop  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("ss_busy",  32'(o_busy),  32'd0);
            chk("ss_valid", 32'(o_valid), 32'd0);
            step();
        end

        // Shadow restored to P=3, B=0: continuous strobes every 4 cycles, no done
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            chk("rst_cfg_valid", 32'(o_valid), 32'(exp_valid(k, 5, 4)));
            chk("rst_cfg_done",  32'(o_done),  32'd0);
            if (k < 40) step();
        end
        chk("rst_cfg_busy",  32'(o_busy),  32'd1);
        chk("rst_cfg_count", 32'(o_count), 32'd9);
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
        chk("final_busy", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/valid_sched.md
VALID_SCHED -- requirements
Module: valid_sched

Interface
REQ-001 The block SHALL have parameter PERIOD_W, default 8, meaning the width of the strobe period field.
REQ-002 The block SHALL have parameter BURST_W, default 16, meaning the width of the burst length and strobe count.
REQ-003 The block SHALL have parameter DEF_PERIOD, default 3, meaning the period value loaded at reset.
REQ-004 Ports SHALL be:
 clk  input  1  clock; all logic on rising edge.
 reset  input  1  reset, asynchronous, active-high.
 i_cfg_we  input  1  config write strobe.
 i_cfg_period  input  PERIOD_W  strobe period P; o_valid spacing is P+1 cycles.
 i_cfg_burst  input  BURST_W  strobes per run B; 0 = continuous.
 i_start  input  1  start request, level-sampled.
 i_stop  input  1  abort request, level-sampled.
 o_valid  output  1  single-cycle datapath enable strobe, registered.
 o_busy  output  1  high while in RUN.
 o_done  output  1  one-cycle pulse on burst completion.
 o_count  output  BURST_W  strobes issued in the current/last run.

Function
REQ-005 FSM states SHALL be IDLE, RUN, DONE.
REQ-006 When i_cfg_we=1, shadow period/burst registers SHALL load i_cfg_period/i_cfg_burst in any state; the active copy SHALL be taken from the shadow registers only on the IDLE->RUN transition.
REQ-007 IDLE->RUN SHALL occur when i_start=1 and i_stop=0 in IDLE; o_count and the period counter SHALL clear to 0 on that transition.
REQ-008 i_start in RUN or DONE SHALL be ignored.
REQ-009 If i_start is sampled in cycle t, the first o_valid SHALL be high in cycle t+P+2, and subsequent o_valid pulses every P+1 cycles; P=0 gives o_valid every cycle.
REQ-010 o_count SHALL increment by 1 in each cycle o_valid is high, wrapping modulo 2^BURST_W in continuous mode.
REQ-011 With B>0, after the B-th o_valid the FSM SHALL enter DONE; o_done SHALL be high for exactly the one cycle after the B-th o_valid, with o_busy low in that cycle; DONE->IDLE unconditionally next cycle.
REQ-012 i_stop=1 in RUN SHALL move to IDLE at the next edge; no o_valid SHALL be asserted after that edge, o_done SHALL NOT pulse, o_count SHALL hold.
REQ-013 i_stop and i_start both high in IDLE: stop SHALL win, FSM stays IDLE.
REQ-014 i_stop coinciding with the B-th strobe's counter terminal cycle: stop SHALL win, no o_done.
REQ-015 o_busy SHALL equal (state==RUN), registered.
REQ-016 Shadow writes during RUN SHALL NOT alter the running strobe spacing or burst length.

Reset
REQ-017 On reset assertion, state SHALL be IDLE, o_valid=0, o_busy=0, o_done=0, o_count=0, counters=0, shadow period=DEF_PERIOD, shadow burst=0, asynchronously.
REQ-018 Reset asserted mid-run SHALL abort immediately with no further o_valid or o_done; after release the block SHALL wait for a new i_start.

Structure
REQ-019 Package valid_sched_pkg SHALL hold PERIOD_W, BURST_W and DEF_PERIOD defaults and the state encoding (IDLE, RUN, DONE).
REQ-020 The period counter SHALL be sub-module valid_tick: inputs clk, reset, clear, enable, period; output registered one-cycle tick when count reaches period, then wraps to 0.
REQ-021 valid_sched SHALL contain only the FSM, shadow/active config registers and o_count.

Verification
REQ-022 Reset, no config, start at t=10 -> o_valid at 15, 19, 23, ...; o_busy high from 11; continuous (B=0).
REQ-023 cfg P=0, B=4, start -> o_valid high 4 consecutive cycles, o_count=4, o_done pulse on next cycle, o_busy low with it, then IDLE.
REQ-024 cfg P=2, B=0, start, stop after 5 strobes -> no further o_valid, o_done never high, o_count holds 5.
REQ-025 cfg P=1, B=3, start; write P=7,B=9 during run -> run keeps P=1, B=3; next start uses P=7, B=9.
REQ-026 i_start and i_stop both high in IDLE -> stays IDLE, o_busy=0; reset asserted between strobes in RUN -> all outputs 0 immediately, shadow P=3.
